hazard_stall_ctrl: RTL

//  Pipeline hazard/stall controller. Drives the hold and flush inputs of the PC, IF/ID, ID/EX
//  and EX/MEM registers. Detects load-use and branch-in-ID data hazards, applies control-flow

---
 rtl/hazard_stall_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch-in-ID interlocks, control-flow
// flushes, data-memory busy freeze with a sticky timeout watchdog, and stall/flush counters.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] D_RegRs,
    input  logic [REG_W-1:0] D_RegRt,
    input  logic             D_UsesRt,
    input  logic             D_Branch,
    input  logic             D_BranchTaken,
    input  logic             EX_MR,
    input  logic             EX_RW,
    input  logic [REG_W-1:0] EX_WR,
    input  logic             EX_Redirect,
    input  logic             MEM_MR,
    input  logic [REG_W-1:0] MEM_WR,
    input  logic             MEM_Busy,
    output logic             PC_Hold,
    output logic             IFID_Hold,
    output logic             IFID_Flush,
    output logic             IDEXWrite,
    output logic             FlushEnable,
    output logic             EXMEM_Hold,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic             BusyTimeout,
    output logic [1:0]       state_dbg
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BUSY    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic [WAIT_W-1:0] wait_inc;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_ex;
    logic br_mem;
    logic stall;
    logic freeze;
    logic flush_any;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    always_comb begin
        ex_match  = (EX_WR != '0) &&
                    ((EX_WR == D_RegRs) || (D_UsesRt && (EX_WR == D_RegRt)));
        mem_match = (MEM_WR != '0) &&
                    ((MEM_WR == D_RegRs) || (D_UsesRt && (MEM_WR == D_RegRt)));
        load_use  = EX_MR && ex_match;
        br_ex     = D_Branch && EX_RW && ex_match;
        br_mem    = D_Branch && MEM_MR && mem_match;
        stall     = load_use || br_ex || br_mem;
    end

    // The freeze tracks MEM_Busy itself, so the cycle memory becomes ready is already
    // released; only the timeout state freezes independently of the input.
    assign freeze = (state == ST_TIMEOUT) || MEM_Busy;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    assign wait_inc = wait_cnt + WAIT_W'(1);

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            ST_RUN, ST_BUSY: begin
                if (MEM_Busy) begin
                    wait_next = wait_inc;
                    if (wait_inc >= WAIT_W'(MAX_WAIT)) begin
                        state_next = ST_TIMEOUT;
                    end else begin
                        state_next = ST_BUSY;
                    end
                end else begin
                    state_next = ST_RUN;
                    wait_next  = '0;
                end
            end
            ST_TIMEOUT: begin
                state_next = ST_TIMEOUT;
            end
            default: begin
                state_next = ST_RUN;
                wait_next  = '0;
            end
        endcase
    end

    // Priority: freeze > redirect > data stall > taken branch > pass-through.
    always_comb begin
        PC_Hold     = 1'b0;
        IFID_Hold   = 1'b0;
        IFID_Flush  = 1'b0;
        IDEXWrite   = 1'b0;
        FlushEnable = 1'b0;
        EXMEM_Hold  = 1'b0;
        if (Rst) begin
            PC_Hold = 1'b0;
        end else if (freeze) begin
            PC_Hold    = 1'b1;
            IFID_Hold  = 1'b1;
            IDEXWrite  = 1'b1;
            EXMEM_Hold = 1'b1;
        end else if (EX_Redirect) begin
            IFID_Flush  = 1'b1;
            FlushEnable = 1'b1;
        end else if (stall) begin
            PC_Hold     = 1'b1;
            IFID_Hold   = 1'b1;
            FlushEnable = 1'b1;
        end else if (D_BranchTaken) begin
            IFID_Flush = 1'b1;
        end
    end

    assign flush_any = IFID_Flush || FlushEnable;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCycles <= '0;
            FlushCount  <= '0;
            BusyTimeout <= 1'b0;
        end else begin
            StallCycles <= StallCycles + {{(CNT_W-1){1'b0}}, PC_Hold};
            FlushCount  <= FlushCount + {{(CNT_W-1){1'b0}}, flush_any};
            if (state_next == ST_TIMEOUT) begin
                BusyTimeout <= 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule
